auth_verifier: RTL and testbench
================================

Name: auth_verifier

Overview:
Verifier (initiator) end of the shared-secret challenge/response authentication handshake.
- Holds its own copy of the secrets An and Mn.
- Issues a 256-bit challenge α from an internal LFSR, asserts call to the prover, and captures the returned β.
- Compares β against the locally computed expected value.
- On a match, pulses suc so the prover updates its secrets, and updates its own copy in lock-step.

Parameters:
W, 256, datapath width (α, β, An, Mn); LFSR taps fixed for 256.
TMO, 64, maximum cycles to wait for beta_vld after call.
SEED, 256'h1, LFSR value after reset and substitute for a zero seed load.

Ports:
CLK  in  1  system clock
RST  in  1  reset, synchronous, active-high
start  in  1  request one authentication round; honoured only in IDLE with key_ok=1
key_ld  in  1  load an_in/mn_in into An/Mn; honoured only in IDLE
an_in  in  W  initial An
mn_in  in  W  initial Mn
seed_ld  in  1  load seed_in into LFSR; honoured only in IDLE
seed_in  in  W  LFSR seed
beta  in  W  response β from prover
beta_vld  in  1  β valid, single-cycle
alpha  out  W  registered challenge α, stable from GEN until the next round
call  out  1  one-cycle pulse, high in state CALL
suc  out  1  one-cycle pulse, high in state UPD
fail  out  1  one-cycle pulse on mismatch or timeout
tmo  out  1  one-cycle pulse, high together with fail only on timeout
key_ok  out  1  secrets loaded
busy  out  1  state != IDLE
st  out  3  current state encoding

Behaviour:
- Reset: state=IDLE, An=Mn=0, key_ok=0, LFSR=SEED, alpha=0, all pulses 0, timer=0. A reset mid-round aborts the round with no pulses and no secret update.
- State encoding: IDLE=000, GEN=001, NCAL=010, BCAL=011, CALL=100, WAIT=101, CHK=110, UPD=111.
- IDLE
  - Priority: key_ld > seed_ld > start. Only one action per cycle; lower-priority requests are dropped, not queued.
  - key_ld: An<=an_in, Mn<=mn_in, key_ok<=1.
  - seed_ld: LFSR<=seed_in, or SEED if seed_in==0.
  - start with key_ok=1: go to GEN. start with key_ok=0 is ignored.
- GEN: alpha<=LFSR; LFSR advances one step (Fibonacci, taps 256,254,251,246, shift left, feedback into bit 0) -> NCAL.
- NCAL: N<=alpha^An^Mn -> BCAL.
- BCAL: E<=(N+An) mod 2^W, carry discarded -> CALL.
- CALL: call=1 for exactly one cycle; timer<=0 -> WAIT.
- WAIT
  - beta_vld=1: capture β, go to CHK.
  - Otherwise timer++; when timer==TMO-1 without beta_vld, pulse fail and tmo, go to IDLE.
  - beta_vld on the same cycle as the last timeout cycle counts as valid (beta_vld wins).
- CHK: β==E -> UPD; else pulse fail -> IDLE.
- UPD: suc=1; Mn<=(An+Mn) mod 2^W; An<=N -> IDLE.
- Latency: start to call = 4 cycles. Capture to suc or fail = 2 cycles (CHK, then UPD/IDLE output).
- Inputs ignored outside their states: start, key_ld and seed_ld while busy; beta_vld outside WAIT, including a late β arriving after a timeout.
- Secrets change only in UPD or on key_ld. A failed round leaves An and Mn untouched, but the LFSR has still advanced.
- All outputs are driven from registers or a state decode only; no input-to-output combinational path.

Decomposition:
- Package auth_pkg: W, state encodings, LFSR tap constants, TMO default.
- Sub-module auth_lfsr (W-bit Fibonacci LFSR with load, step and zero-seed guard).
- Remaining FSM and datapath live in auth_verifier.

Test Plan:
- Reset, key_ld An=1 Mn=2, seed_ld 5, start -> alpha=5, call at start+4. Reply beta=7 -> suc pulse; An=6, Mn=3, fail=0.
- Same setup, reply beta=8 -> fail pulse, tmo=0, An=1 and Mn=2 unchanged; next start yields alpha=LFSR successor of 5 (0xA).
- No beta_vld after call -> fail and tmo pulse exactly TMO cycles after call; beta_vld one cycle later is ignored.
- start with key_ok=0 -> stays IDLE, no call. key_ld and start in the same cycle -> keys loaded, no round started.
- Overflow: An=Mn=2^256-1, seed 0 (becomes SEED=1) -> alpha=1, N=1, expected β=0; reply 0 -> suc, Mn=2^256-2, An=1.
- RST asserted in WAIT -> next cycle IDLE, key_ok=0, no suc or fail, alpha=0.

Source files
------------

// File: rtl/auth_pkg.sv
// Shared constants and state encoding for the challenge/response verifier.
package auth_pkg;

    localparam int AUTH_W  = 256;
    localparam int TMO_DEF = 64;

    // Fibonacci LFSR tap positions (1-based) for the 256-bit challenge generator
    localparam int TAP_A = 256;
    localparam int TAP_B = 254;
    localparam int TAP_C = 251;
    localparam int TAP_D = 246;

    typedef enum logic [2:0] {
        S_IDLE = 3'b000,
        S_GEN  = 3'b001,
        S_NCAL = 3'b010,
        S_BCAL = 3'b011,
        S_CALL = 3'b100,
        S_WAIT = 3'b101,
        S_CHK  = 3'b110,
        S_UPD  = 3'b111
    } state_t;

endpackage

// File: rtl/auth_if.sv
// Handshake and data bundle between the verifier core and its host/prover side.
interface auth_if #(parameter int W = auth_pkg::AUTH_W);

    logic         start;
    logic         key_ld;
    logic [W-1:0] an_in;
    logic [W-1:0] mn_in;
    logic         seed_ld;
    logic [W-1:0] seed_in;
    logic [W-1:0] beta;
    logic         beta_vld;
    logic [W-1:0] alpha;
    logic         call;
    logic         suc;
    logic         fail;
    logic         tmo;
    logic         key_ok;
    logic         busy;
    logic [2:0]   st;

    modport master (
        output start, key_ld, an_in, mn_in, seed_ld, seed_in, beta, beta_vld,
        input  alpha, call, suc, fail, tmo, key_ok, busy, st
    );

    modport slave (
        input  start, key_ld, an_in, mn_in, seed_ld, seed_in, beta, beta_vld,
        output alpha, call, suc, fail, tmo, key_ok, busy, st
    );

endinterface

// File: rtl/auth_lfsr.sv
// Challenge source: shift-left Fibonacci LFSR with parallel load; a zero load
// would lock the register, so it is replaced by SEED.
module auth_lfsr
    import auth_pkg::*;
#(
    parameter int           W    = AUTH_W,
    parameter logic [W-1:0] SEED = W'(1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ld,
    input  logic         step,
    input  logic [W-1:0] din,
    output logic [W-1:0] q
);

    logic fb;

    assign fb = q[TAP_A-1] ^ q[TAP_B-1] ^ q[TAP_C-1] ^ q[TAP_D-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= SEED;
        end else if (ld) begin
            q <= (din == '0) ? SEED : din;
        end else if (step) begin
            q <= {q[W-2:0], fb};
        end
    end

endmodule

// File: rtl/auth_verifier.sv
// Verifier end of the shared-secret handshake: issues a challenge, checks the
// prover's response and rolls the shared secrets forward on success.
module auth_verifier
    import auth_pkg::*;
#(
    parameter int           W    = AUTH_W,
    parameter int           TMO  = TMO_DEF,
    parameter logic [W-1:0] SEED = W'(1)
) (
    input  logic CLK,
    input  logic RST,
    auth_if.slave bus
);

    localparam int            TW     = $clog2(TMO + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TMO - 1);

    state_t        state, nxt;
    logic [W-1:0]  an, mn, n_val, e_val, beta_q, alpha_q, lfsr_q;
    logic          key_ok_q, fail_q, tmo_q;
    logic [TW-1:0] timer;
    logic          idle, do_key, do_seed, do_start, timeout, mismatch;

    // IDLE requests are strictly prioritised; losers are dropped
    assign idle     = (state == S_IDLE);
    assign do_key   = idle & bus.key_ld;
    assign do_seed  = idle & ~bus.key_ld & bus.seed_ld;
    assign do_start = idle & ~bus.key_ld & ~bus.seed_ld & bus.start & key_ok_q;
    assign timeout  = (state == S_WAIT) & ~bus.beta_vld & (timer == T_LAST);
    assign mismatch = (beta_q != e_val);

    auth_lfsr #(.W(W), .SEED(SEED)) u_lfsr (
        .clk  (CLK),
        .rst  (RST),
        .ld   (do_seed),
        .step (state == S_GEN),
        .din  (bus.seed_in),
        .q    (lfsr_q)
    );

    always_ff @(posedge CLK) begin
        if (RST) state <= S_IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE: if (do_start) nxt = S_GEN;
            S_GEN:  nxt = S_NCAL;
            S_NCAL: nxt = S_BCAL;
            S_BCAL: nxt = S_CALL;
            S_CALL: nxt = S_WAIT;
            S_WAIT: begin
                if (bus.beta_vld)         nxt = S_CHK;
                else if (timer == T_LAST) nxt = S_IDLE;
            end
            S_CHK:  nxt = mismatch ? S_IDLE : S_UPD;
            S_UPD:  nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
    end

    always_comb begin
        bus.call = (state == S_CALL);
        bus.suc  = (state == S_UPD);
        bus.busy = (state != S_IDLE);
        bus.st   = state;
    end

    assign bus.alpha  = alpha_q;
    assign bus.fail   = fail_q;
    assign bus.tmo    = tmo_q;
    assign bus.key_ok = key_ok_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            key_ok_q <= 1'b0;
            fail_q   <= 1'b0;
            tmo_q    <= 1'b0;
            timer    <= '0;
        end else begin
            fail_q <= timeout | ((state == S_CHK) & mismatch);
            tmo_q  <= timeout;
            if (do_key) key_ok_q <= 1'b1;
            if (state == S_CALL)      timer <= '0;
            else if (state == S_WAIT) timer <= timer + TW'(1);
        end
    end

    // Secrets and challenge are architecturally visible after reset, so they clear
    always_ff @(posedge CLK) begin
        if (RST) begin
            an      <= '0;
            mn      <= '0;
            alpha_q <= '0;
        end else begin
            if (state == S_GEN) alpha_q <= lfsr_q;
            if (do_key) begin
                an <= bus.an_in;
                mn <= bus.mn_in;
            end else if (state == S_UPD) begin
                an <= n_val;
                mn <= an + mn;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (state == S_NCAL) n_val <= alpha_q ^ an ^ mn;
        if (state == S_BCAL) e_val <= n_val + an;
        if ((state == S_WAIT) && bus.beta_vld) beta_q <= bus.beta;
    end

endmodule

// File: tb/tb_auth_verifier.sv
// Randomized bench for auth_verifier against a round-level model of the handshake.
module tb_auth_verifier;

    localparam int W   = 256;
    localparam int TMO = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests_run = 0;
    int   tests_failed = 0;

    logic [W-1:0] m_an, m_mn, m_lfsr;

    auth_if #(.W(W)) bus ();

    auth_verifier #(.W(W), .TMO(TMO)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [W-1:0] lfsr_succ(input logic [W-1:0] s);
        return {s[W-2:0], s[255] ^ s[253] ^ s[250] ^ s[245]};
    endfunction

    function automatic logic [W-1:0] rand_w();
        return {$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        m_an = '0;
        m_mn = '0;
        m_lfsr = W'(1);
    endtask

    task automatic load_keys(input logic [W-1:0] a, input logic [W-1:0] m);
        bus.key_ld = 1'b1;
        bus.an_in  = a;
        bus.mn_in  = m;
        step();
        bus.key_ld = 1'b0;
        m_an = a;
        m_mn = m;
    endtask

    task automatic load_seed(input logic [W-1:0] s);
        bus.seed_ld = 1'b1;
        bus.seed_in = s;
        step();
        bus.seed_ld = 1'b0;
        m_lfsr = (s == '0) ? W'(1) : s;
    endtask

    // mode 0: correct reply, 1: reply e^mask, 2: no reply (timeout)
    task automatic run_round(input int mode, input int delay, input logic [W-1:0] mask,
                             input bit spam, input string tag);
        logic [W-1:0] exp_alpha, n, e;
        int  cyc;
        bit  got;
        bit  stray;
        exp_alpha = m_lfsr;
        m_lfsr = lfsr_succ(m_lfsr);
        n = exp_alpha ^ m_an ^ m_mn;
        e = n + m_an;

        bus.start = 1'b1;
        cyc = 0;
        got = 0;
        while (!got && cyc < 10) begin
            step();
            bus.start = 1'b0;
            cyc++;
            if (bus.call === 1'b1) got = 1;
        end
        tests_run++;
        if (!got || cyc != 4) begin
            tests_failed++;
            $display("FAIL %s call_latency: got %0d cycles (seen=%0d), need 4", tag, cyc, got);
            return;
        end
        tests_run++;
        if (bus.alpha !== exp_alpha) begin
            tests_failed++;
            $display("FAIL %s alpha: got %h need %h", tag, bus.alpha, exp_alpha);
        end
        step();
        tests_run++;
        if (bus.call !== 1'b0 || bus.st !== 3'd5) begin
            tests_failed++;
            $display("FAIL %s call_width: call=%b st=%0d, need call=0 st=5", tag, bus.call, bus.st);
        end

        if (mode == 2) begin
            cyc = 0;
            got = 0;
            while (!got && cyc < TMO + 10) begin
                step();
                cyc++;
                if (bus.fail === 1'b1) got = 1;
            end
            tests_run++;
            if (!got || cyc != TMO || bus.tmo !== 1'b1 || bus.suc !== 1'b0) begin
                tests_failed++;
                $display("FAIL %s timeout: seen=%0d after %0d cycles tmo=%b suc=%b, need fail+tmo after %0d",
                         tag, got, cyc, bus.tmo, bus.suc, TMO);
            end
            bus.beta = e;
            bus.beta_vld = 1'b1;
            step();
            bus.beta_vld = 1'b0;
            step();
            tests_run++;
            if ({bus.suc, bus.fail, bus.tmo} !== 3'b000 || bus.busy !== 1'b0) begin
                tests_failed++;
                $display("FAIL %s late_beta: suc/fail/tmo=%b busy=%b, need 000 busy=0",
                         tag, {bus.suc, bus.fail, bus.tmo}, bus.busy);
            end
            return;
        end

        stray = 0;
        for (int i = 0; i < delay; i++) begin
            if (spam) begin
                bus.key_ld  = $urandom_range(0, 1);
                bus.seed_ld = $urandom_range(0, 1);
                bus.start   = $urandom_range(0, 1);
                bus.an_in   = rand_w();
                bus.mn_in   = rand_w();
                bus.seed_in = rand_w();
            end
            step();
            if (bus.suc !== 1'b0 || bus.fail !== 1'b0 || bus.st !== 3'd5) stray = 1;
        end
        bus.key_ld = 1'b0;
        bus.seed_ld = 1'b0;
        bus.start = 1'b0;
        tests_run++;
        if (stray) begin
            tests_failed++;
            $display("FAIL %s wait_quiet: left WAIT or pulsed within %0d cycles, need steady WAIT", tag, delay);
        end

        bus.beta = (mode == 0) ? e : (e ^ mask);
        bus.beta_vld = 1'b1;
        step();
        bus.beta_vld = 1'b0;
        tests_run++;
        if (bus.st !== 3'd6 || bus.suc !== 1'b0 || bus.fail !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s chk_state: st=%0d suc=%b fail=%b, need st=6 no pulses", tag, bus.st, bus.suc, bus.fail);
        end
        step();
        tests_run++;
        if ({bus.suc, bus.fail, bus.tmo} !== ((mode == 0) ? 3'b100 : 3'b010)) begin
            tests_failed++;
            $display("FAIL %s verdict: suc/fail/tmo=%b need %b", tag, {bus.suc, bus.fail, bus.tmo},
                     (mode == 0) ? 3'b100 : 3'b010);
        end
        if (mode == 0) begin
            m_mn = m_an + m_mn;
            m_an = n;
        end
        step();
        tests_run++;
        if ({bus.suc, bus.fail, bus.tmo} !== 3'b000 || bus.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s post_round: suc/fail/tmo=%b busy=%b, need 000 busy=0",
                     tag, {bus.suc, bus.fail, bus.tmo}, bus.busy);
        end
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if (bus.st !== 3'd0 || bus.busy !== 1'b0 || bus.key_ok !== 1'b0 || bus.alpha !== '0 ||
            {bus.call, bus.suc, bus.fail, bus.tmo} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_state: st=%0d busy=%b key_ok=%b alpha_nz=%b pulses=%b, need all zero",
                     bus.st, bus.busy, bus.key_ok, bus.alpha != '0, {bus.call, bus.suc, bus.fail, bus.tmo});
        end
        // LFSR must come out of reset at SEED
        load_keys(rand_w(), rand_w());
        run_round(0, 3, '0, 0, "reset_seed");
    endtask

    task automatic test_basic();
        do_reset();
        load_keys(W'(1), W'(2));
        load_seed(W'(5));
        run_round(0, 2, '0, 0, "basic");
        tests_run++;
        if (m_an !== W'(6) || m_mn !== W'(3)) begin
            tests_failed++;
            $display("FAIL basic_model: model An=%0h Mn=%0h need 6/3", m_an, m_mn);
        end
        // the follow-up only succeeds if the DUT holds An=6, Mn=3
        run_round(0, 0, '0, 0, "basic_followup");
    endtask

    task automatic test_mismatch();
        do_reset();
        load_keys(W'(1), W'(2));
        load_seed(W'(5));
        run_round(1, 1, W'(15), 0, "mismatch");
        tests_run++;
        if (m_lfsr !== W'(10)) begin
            tests_failed++;
            $display("FAIL mismatch_model: model lfsr=%0h need a", m_lfsr);
        end
        run_round(0, 4, '0, 0, "mismatch_retry");
    endtask

    task automatic test_timeout();
        do_reset();
        load_keys(rand_w(), rand_w());
        run_round(2, 0, '0, 0, "timeout");
        run_round(0, TMO - 1, '0, 0, "last_cycle_beta");
        run_round(0, 5, '0, 0, "after_timeout");
    endtask

    task automatic test_priority();
        logic [W-1:0] keep;
        do_reset();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        tests_run++;
        if (bus.busy !== 1'b0 || bus.st !== 3'd0) begin
            tests_failed++;
            $display("FAIL no_key_start: busy=%b st=%0d, need idle", bus.busy, bus.st);
        end
        bus.start = 1'b1;
        load_keys(rand_w(), rand_w());
        bus.start = 1'b0;
        tests_run++;
        if (bus.key_ok !== 1'b1 || bus.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL key_and_start: key_ok=%b busy=%b, need 1/0", bus.key_ok, bus.busy);
        end
        for (int i = 0; i < 6; i++) step();
        tests_run++;
        if (bus.busy !== 1'b0 || bus.call !== 1'b0) begin
            tests_failed++;
            $display("FAIL key_and_start_late: busy=%b call=%b, need 0/0", bus.busy, bus.call);
        end
        // key_ld outranks seed_ld: the seed is dropped
        keep = m_lfsr;
        bus.seed_ld = 1'b1;
        bus.seed_in = rand_w();
        load_keys(rand_w(), rand_w());
        bus.seed_ld = 1'b0;
        m_lfsr = keep;
        run_round(0, 2, '0, 0, "key_over_seed");
        // seed_ld outranks start: seed loaded, no round
        bus.start = 1'b1;
        load_seed(rand_w());
        bus.start = 1'b0;
        step();
        tests_run++;
        if (bus.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL seed_and_start: busy=%b, need 0", bus.busy);
        end
        run_round(0, 1, '0, 0, "seed_over_start");
    endtask

    task automatic test_overflow();
        do_reset();
        load_keys('1, '1);
        load_seed('0);
        run_round(0, 0, '0, 0, "overflow");
        tests_run++;
        if (m_an !== W'(1) || m_mn !== {{(W-1){1'b1}}, 1'b0}) begin
            tests_failed++;
            $display("FAIL overflow_model: model An=%h Mn=%h", m_an, m_mn);
        end
        run_round(0, 0, '0, 0, "overflow_followup");
    endtask

    task automatic test_reset_in_wait();
        bit stray;
        do_reset();
        load_keys(rand_w(), rand_w());
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < 6; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        m_an = '0;
        m_mn = '0;
        m_lfsr = W'(1);
        tests_run++;
        if (bus.st !== 3'd0 || bus.key_ok !== 1'b0 || bus.alpha !== '0 ||
            bus.suc !== 1'b0 || bus.fail !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_in_wait: st=%0d key_ok=%b alpha_nz=%b suc=%b fail=%b, need idle/cleared",
                     bus.st, bus.key_ok, bus.alpha != '0, bus.suc, bus.fail);
        end
        stray = 0;
        for (int i = 0; i < TMO + 4; i++) begin
            step();
            if (bus.suc !== 1'b0 || bus.fail !== 1'b0 || bus.busy !== 1'b0) stray = 1;
        end
        tests_run++;
        if (stray) begin
            tests_failed++;
            $display("FAIL reset_in_wait_quiet: pulse or activity after abort, need none");
        end
        load_keys(rand_w(), rand_w());
        run_round(0, 2, '0, 0, "after_abort");
    endtask

    task automatic test_back_to_back();
        int mode;
        do_reset();
        load_keys(rand_w(), rand_w());
        for (int r = 0; r < 24; r++) begin
            if ($urandom_range(0, 5) == 0) load_keys(rand_w(), rand_w());
            if ($urandom_range(0, 5) == 0) load_seed(($urandom_range(0, 3) == 0) ? '0 : rand_w());
            mode = ($urandom_range(0, 9) == 0) ? 2 : (($urandom_range(0, 3) == 0) ? 1 : 0);
            run_round(mode, $urandom_range(0, TMO - 1), rand_w() | W'(1), $urandom_range(0, 1), "random");
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.key_ld = 1'b0;
        bus.seed_ld = 1'b0;
        bus.beta_vld = 1'b0;
        bus.an_in = '0;
        bus.mn_in = '0;
        bus.seed_in = '0;
        bus.beta = '0;
        test_reset();
        test_basic();
        test_mismatch();
        test_timeout();
        test_priority();
        test_overflow();
        test_reset_in_wait();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
